// File: rtl/antirrebote_botones_if.sv
// Button bundle shared by the board pins, the debouncer and the pet state machine.
interface antirrebote_botones_if #(
    parameter int N_BOTONES = 2
);
    logic [N_BOTONES-1:0] botones_raw;
    logic [N_BOTONES-1:0] nivel;
    logic [N_BOTONES-1:0] pulso;
    logic [N_BOTONES-1:0] pulso_largo;

    modport master (output botones_raw, input nivel, input pulso, input pulso_largo);
    modport slave  (input botones_raw, output nivel, output pulso, output pulso_largo);
endinterface

// File: rtl/antirrebote_botones.sv
// Per-button synchroniser, debouncer and press / long-press pulse generator.
// Optional long-press logic is compiled in when PULSACION_LARGA_EN is defined.
module antirrebote_botones #(
    parameter int N_BOTONES       = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    antirrebote_botones_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        REPOSO,
        CONFIRMA_PRESION,
        PRESIONADO,
        MANTENIDO,
        CONFIRMA_SUELTA
    } estado_t;

    logic [N_BOTONES-1:0] w_nivel;
    logic [N_BOTONES-1:0] w_pulso;
    logic [N_BOTONES-1:0] w_largo;

    for (genvar g = 0; g < N_BOTONES; g++) begin : g_canal
        logic          r_sync1;
        logic          r_sync2;
        logic [DW-1:0] r_cnt;
        logic          r_nivel;
        logic          r_pulso;
        estado_t       r_estado;
        estado_t       w_estado_sig;
        logic          w_difiere;
        logic          w_hecho;
        logic          w_pulso_sig;
        logic          w_largo_sig;
        logic          w_mantenido;

        assign w_difiere = (r_sync2 != r_nivel);
        assign w_hecho   = w_difiere && (r_cnt == DMAX);

`ifdef PULSACION_LARGA_EN
        localparam int HW = $clog2(LONG_CYCLES + 1);
        localparam logic [HW-1:0] LMAX = HW'(LONG_CYCLES);
        localparam logic [HW-1:0] LPRE = HW'(LONG_CYCLES - 1);

        logic [HW-1:0] r_hold;
        logic          r_largo;

        // Hold counter saturates so a long hold yields exactly one long pulse.
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_hold  <= '0;
                r_largo <= 1'b0;
            end else begin
                if (!r_nivel)
                    r_hold <= '0;
                else if (r_hold != LMAX)
                    r_hold <= r_hold + HW'(1);
                r_largo <= w_largo_sig;
            end
        end

        assign w_mantenido = (r_hold == LMAX) || w_largo_sig;
        assign w_largo[g]  = r_largo;
`else
        assign w_mantenido = 1'b0;
        assign w_largo[g]  = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_sync1  <= 1'b0;
                r_sync2  <= 1'b0;
                r_cnt    <= '0;
                r_nivel  <= 1'b0;
                r_pulso  <= 1'b0;
                r_estado <= REPOSO;
            end else begin
                r_sync1  <= bus.botones_raw[g];
                r_sync2  <= r_sync1;
                r_estado <= w_estado_sig;
                if (!w_difiere || w_hecho)
                    r_cnt <= '0;
                else
                    r_cnt <= r_cnt + DW'(1);
                r_nivel  <= r_nivel ^ w_hecho;
                r_pulso  <= w_pulso_sig;
            end
        end

        // A bounce back during release resumes the pressed state it came from.
        always_comb begin
            w_estado_sig = r_estado;
            case (r_estado)
                REPOSO: begin
                    if (r_sync2)
                        w_estado_sig = CONFIRMA_PRESION;
                end
                CONFIRMA_PRESION: begin
                    if (!r_sync2)
                        w_estado_sig = REPOSO;
                    else if (w_hecho)
                        w_estado_sig = PRESIONADO;
                end
                PRESIONADO: begin
                    if (!r_sync2)
                        w_estado_sig = CONFIRMA_SUELTA;
                    else if (w_largo_sig)
                        w_estado_sig = MANTENIDO;
                end
                MANTENIDO: begin
                    if (!r_sync2)
                        w_estado_sig = CONFIRMA_SUELTA;
                end
                CONFIRMA_SUELTA: begin
                    if (r_sync2)
                        w_estado_sig = w_mantenido ? MANTENIDO : PRESIONADO;
                    else if (w_hecho)
                        w_estado_sig = REPOSO;
                end
                default: w_estado_sig = REPOSO;
            endcase
        end

        always_comb begin
            w_pulso_sig = (r_estado == CONFIRMA_PRESION) && w_hecho;
            w_largo_sig = 1'b0;
`ifdef PULSACION_LARGA_EN
            w_largo_sig = r_nivel && (r_hold == LPRE);
`endif
        end

        assign w_nivel[g] = r_nivel;
        assign w_pulso[g] = r_pulso;
    end

    assign bus.nivel       = w_nivel;
    assign bus.pulso       = w_pulso;
    assign bus.pulso_largo = w_largo;
endmodule

// File: tb/tb_antirrebote_botones.sv
// Randomised and directed bench for antirrebote_botones against a run-length reference model.
module tb_antirrebote_botones;
    localparam int N = 2;
    localparam int D = 4;
    localparam int L = 10;
`ifdef PULSACION_LARGA_EN
    localparam bit LARGO_EN = 1'b1;
`else
    localparam bit LARGO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    antirrebote_botones_if #(.N_BOTONES(N)) bif ();

    antirrebote_botones #(
        .N_BOTONES       (N),
        .DEBOUNCE_CYCLES (D),
        .LONG_CYCLES     (L)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference: s lags raw by two edges; level flips after D consecutive differing edges.
    logic m_d1[N], m_d2[N], m_nivel[N], m_pulso[N], m_largo[N];
    int   m_run[N], m_held[N];

    task automatic model_edge(input logic [N-1:0] raw, input logic rst_n);
        logic s;
        for (int c = 0; c < N; c++) begin
            if (!rst_n) begin
                m_d1[c] = 1'b0; m_d2[c] = 1'b0; m_run[c] = 0; m_held[c] = 0;
                m_nivel[c] = 1'b0; m_pulso[c] = 1'b0; m_largo[c] = 1'b0;
            end else begin
                s = m_d2[c];
                m_d2[c] = m_d1[c];
                m_d1[c] = raw[c];
                m_largo[c] = 1'b0;
                if (m_nivel[c]) begin
                    m_held[c]++;
                    if (LARGO_EN && m_held[c] == L) m_largo[c] = 1'b1;
                end else begin
                    m_held[c] = 0;
                end
                m_pulso[c] = 1'b0;
                if (s != m_nivel[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_nivel[c] = ~m_nivel[c];
                        m_run[c] = 0;
                        m_pulso[c] = m_nivel[c];
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
        end
    endtask

    function automatic logic [5:0] expected();
        return {m_nivel[1], m_nivel[0], m_pulso[1], m_pulso[0], m_largo[1], m_largo[0]};
    endfunction

    function automatic logic [5:0] observed();
        return {bif.nivel, bif.pulso, bif.pulso_largo};
    endfunction

    task automatic tick(input logic [N-1:0] raw, input logic rst_n);
        @(negedge clk);
        bif.botones_raw = raw;
        reset = rst_n;
        @(posedge clk);
        model_edge(raw, rst_n);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(2'b11, 1'b0);
            vectors++;
            if (observed() !== 6'b0) begin
                miscompares++;
                $display("FAIL reset cycle %0d: got %b want %b", i, observed(), 6'b0);
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick(2'b00, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL reset_idle cycle %0d: got %b want %b", i, observed(), expected());
            end
        end
    endtask

    task automatic test_clean_press();
        int p_idx = -1, p_cnt = 0, p1_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick(2'b01, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL clean_press cycle %0d: got %b want %b", i, observed(), expected());
            end
            if (bif.pulso[0] === 1'b1) begin p_cnt++; if (p_idx < 0) p_idx = i; end
            if (bif.pulso[1] === 1'b1) p1_cnt++;
        end
        vectors++;
        if (p_idx !== 5 || p_cnt !== 1 || p1_cnt !== 0) begin
            miscompares++;
            $display("FAIL clean_press_timing: got idx=%0d cnt=%0d p1=%0d want idx=5 cnt=1 p1=0", p_idx, p_cnt, p1_cnt);
        end
        for (int i = 0; i < 12; i++) begin
            tick(2'b00, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL clean_release cycle %0d: got %b want %b", i, observed(), expected());
            end
        end
    endtask

    task automatic test_bounce();
        int p_idx = -1, p_cnt = 0, early = 0;
        logic [1:0] raw;
        for (int i = 0; i < 30; i++) begin
            raw = (i < 12) ? {((i / 2) % 2 == 0), 1'b0} : 2'b10;
            tick(raw, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL bounce cycle %0d: got %b want %b", i, observed(), expected());
            end
            if (i < 17 && observed() !== 6'b0) early++;
            if (bif.pulso[1] === 1'b1) begin p_cnt++; if (p_idx < 0) p_idx = i; end
        end
        vectors++;
        if (p_idx !== 17 || p_cnt !== 1 || early !== 0) begin
            miscompares++;
            $display("FAIL bounce_timing: got idx=%0d cnt=%0d early=%0d want idx=17 cnt=1 early=0", p_idx, p_cnt, early);
        end
        for (int i = 0; i < 12; i++) begin
            tick(2'b00, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL bounce_release cycle %0d: got %b want %b", i, observed(), expected());
            end
        end
    endtask

    task automatic test_long_press();
        int p_idx = -1, l_idx = -1, l_cnt = 0, both = 0;
        for (int i = 0; i < 30; i++) begin
            tick(2'b01, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL long_press cycle %0d: got %b want %b", i, observed(), expected());
            end
            if (bif.pulso[0] === 1'b1 && p_idx < 0) p_idx = i;
            if (bif.pulso_largo[0] === 1'b1) begin l_cnt++; if (l_idx < 0) l_idx = i; end
            if ((bif.pulso & bif.pulso_largo) !== 2'b00) both++;
        end
        vectors++;
        if (LARGO_EN ? (l_cnt !== 1 || l_idx - p_idx !== 10 || p_idx !== 5 || both !== 0)
                     : (l_cnt !== 0 || p_idx !== 5)) begin
            miscompares++;
            $display("FAIL long_press_timing: got pulso=%0d largo=%0d cnt=%0d overlap=%0d want pulso=5 largo=%0d cnt=%0d",
                     p_idx, l_idx, l_cnt, both, LARGO_EN ? 15 : -1, LARGO_EN ? 1 : 0);
        end
        for (int i = 0; i < 12; i++) begin
            tick(2'b00, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL long_release cycle %0d: got %b want %b", i, observed(), expected());
            end
        end
    endtask

    task automatic test_release_glitch();
        int p_cnt = 0, l_idx = -1, drops = 0;
        for (int i = 0; i < 34; i++) begin
            tick((i == 12 || i == 13) ? 2'b00 : 2'b01, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL release_glitch cycle %0d: got %b want %b", i, observed(), expected());
            end
            if (bif.pulso[0] === 1'b1) p_cnt++;
            if (bif.pulso_largo[0] === 1'b1 && l_idx < 0) l_idx = i;
            if (i >= 5 && bif.nivel[0] !== 1'b1) drops++;
        end
        vectors++;
        if (p_cnt !== 1 || drops !== 0 || l_idx !== (LARGO_EN ? 15 : -1)) begin
            miscompares++;
            $display("FAIL release_glitch_summary: got pulses=%0d drops=%0d largo=%0d want 1 0 %0d",
                     p_cnt, drops, l_idx, LARGO_EN ? 15 : -1);
        end
        for (int i = 0; i < 12; i++) begin
            tick(2'b00, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL glitch_release cycle %0d: got %b want %b", i, observed(), expected());
            end
        end
    endtask

    task automatic test_reset_mid_press();
        int p_idx = -1;
        for (int i = 0; i < 8; i++) begin
            tick(2'b10, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL mid_press cycle %0d: got %b want %b", i, observed(), expected());
            end
        end
        tick(2'b10, 1'b0);
        vectors++;
        if (observed() !== 6'b0) begin
            miscompares++;
            $display("FAIL mid_reset_clear: got %b want %b", observed(), 6'b0);
        end
        for (int i = 1; i < 12; i++) begin
            tick(2'b10, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL mid_rearm cycle %0d: got %b want %b", i, observed(), expected());
            end
            if (bif.pulso[1] === 1'b1 && p_idx < 0) p_idx = i;
        end
        vectors++;
        if (p_idx !== 6) begin
            miscompares++;
            $display("FAIL mid_rearm_timing: got %0d want 6", p_idx);
        end
        for (int i = 0; i < 12; i++) begin
            tick(2'b00, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL mid_release cycle %0d: got %b want %b", i, observed(), expected());
            end
        end
    endtask

    task automatic test_simultaneous();
        int both_idx = -1;
        for (int i = 0; i < 10; i++) begin
            tick(2'b11, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL simultaneous cycle %0d: got %b want %b", i, observed(), expected());
            end
            if (bif.pulso === 2'b11 && both_idx < 0) both_idx = i;
        end
        vectors++;
        if (both_idx !== 5) begin
            miscompares++;
            $display("FAIL simultaneous_timing: got %0d want 5", both_idx);
        end
        for (int i = 0; i < 12; i++) begin
            tick(2'b00, 1'b1);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL simultaneous_release cycle %0d: got %b want %b", i, observed(), expected());
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] raw = 2'b00;
        logic       rst_n;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) raw[c] = ~raw[c];
            rst_n = ($urandom_range(0, 299) != 0);
            tick(raw, rst_n);
            vectors++;
            if (observed() !== expected()) begin
                miscompares++;
                $display("FAIL random cycle %0d raw=%b rst=%b: got %b want %b", i, raw, rst_n, observed(), expected());
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        bif.botones_raw = '0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_release_glitch();
        test_reset_mid_press();
        test_simultaneous();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
